// File: rtl/bsg_link_bringup_pkg.sv
// bsg_link_bringup_pkg: shared state encoding and timer sizing for the link bring-up sequencer
package bsg_link_bringup_pkg;
  typedef enum logic [2:0] {S_PRE, S_LRST, S_POST, S_LEN, S_NODE, S_DONE, S_FAIL} state_e;
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/bsg_bringup_phase_timer.sv
// bsg_bringup_phase_timer: clearable up-counter that pulses expire_o on its last enabled cycle
module bsg_bringup_phase_timer
  import bsg_link_bringup_pkg::*;
#(parameter int cycles_p = 5000)
 (input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o);
  localparam int w_lp = timer_width(cycles_p);
  logic [w_lp-1:0] count_r;
  assign expire_o = en_i && (count_r == w_lp'(cycles_p - 1));
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) count_r <= '0;
    else if (clear_i || expire_o) count_r <= '0;
    else if (en_i) count_r <= count_r + 1'b1;
endmodule

// File: rtl/bsg_link_bringup_sequencer.sv
// bsg_link_bringup_sequencer: timed link/chip/node bring-up with restart and retry budget.
// Define BSG_LINK_BRINGUP_TIMEOUT_EN to add the link_up_i watchdog in S_DONE.
module bsg_link_bringup_sequencer
  import bsg_link_bringup_pkg::*;
#(parameter int phase_cycles_p   = 5000,
  parameter int num_links_p      = 2,
  parameter int max_retries_p    = 3,
  parameter int timeout_cycles_p = 65536,
  localparam int rw_lp = (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1)
 (input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   restart_i,
  input  logic [num_links_p-1:0] link_error_i,
  input  logic [num_links_p-1:0] link_up_i,
  output logic                   link_reset_o,
  output logic                   chip_reset_o,
  output logic [num_links_p-1:0] link_enable_o,
  output logic [num_links_p-1:0] node_en_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [rw_lp-1:0]       retry_count_o);
  localparam int iw_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1;
  state_e state_r;
  logic [iw_lp-1:0] link_idx_r;
  logic timed, phase_expire, wd_expire, restart_ev, at_max;
  assign timed = state_r inside {S_PRE, S_LRST, S_POST, S_LEN, S_NODE};
  assign at_max = retry_count_o == rw_lp'(max_retries_p);
  assign restart_ev = (state_r != S_FAIL) && (restart_i || (state_r == S_DONE && |link_error_i) || wd_expire);
  bsg_bringup_phase_timer #(.cycles_p(phase_cycles_p)) phase_timer
    (.clk_i(clk_i), .reset_i(reset_i), .clear_i(restart_ev), .en_i(timed), .expire_o(phase_expire));
`ifdef BSG_LINK_BRINGUP_TIMEOUT_EN
  // counts consecutive S_DONE cycles with any link not up
  bsg_bringup_phase_timer #(.cycles_p(timeout_cycles_p)) watchdog
    (.clk_i(clk_i), .reset_i(reset_i), .clear_i(state_r != S_DONE || &link_up_i),
     .en_i(state_r == S_DONE && !(&link_up_i)), .expire_o(wd_expire));
`else
  logic unused_wd;
  assign unused_wd = (^link_up_i) ^ (timeout_cycles_p > 0);
  assign wd_expire = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_r <= S_PRE;
      link_idx_r <= '0;
      link_reset_o <= 1'b0;
      chip_reset_o <= 1'b1;
      link_enable_o <= '0;
      node_en_o <= '0;
      done_o <= 1'b0;
      fail_o <= 1'b0;
      retry_count_o <= '0;
    end else if (restart_ev) begin
      // FAIL drives the same output values as reset apart from fail_o
      state_r <= at_max ? S_FAIL : S_PRE;
      fail_o <= at_max;
      if (!at_max) retry_count_o <= retry_count_o + 1'b1;
      link_idx_r <= '0;
      link_reset_o <= 1'b0;
      chip_reset_o <= 1'b1;
      link_enable_o <= '0;
      node_en_o <= '0;
      done_o <= 1'b0;
    end else if (phase_expire) begin
      case (state_r)
        S_PRE:  begin state_r <= S_LRST; link_reset_o <= 1'b1; end
        S_LRST: begin state_r <= S_POST; link_reset_o <= 1'b0; end
        S_POST: begin state_r <= S_LEN;  link_enable_o <= '1; end
        S_LEN:  begin state_r <= S_NODE; chip_reset_o <= 1'b0; end
        S_NODE: begin
          node_en_o[link_idx_r] <= 1'b1;
          if (link_idx_r == iw_lp'(num_links_p - 1)) begin
            state_r <= S_DONE;
            done_o <= 1'b1;
          end else link_idx_r <= link_idx_r + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bsg_link_bringup_sequencer.sv
// tb_bsg_link_bringup_sequencer: random restarts/errors/resets checked against a time-since-start model
module tb_bsg_link_bringup_sequencer;
  localparam int P = 4, N = 2, MR = 3, TO = 8;
  localparam int DONE_T = (4 + N) * P;
  logic clk = 1'b0;
  logic reset_i, restart_i;
  logic [N-1:0] link_error_i, link_up_i, link_enable_o, node_en_o;
  logic link_reset_o, chip_reset_o, done_o, fail_o;
  logic [1:0] retry_count_o;
  int n_cmp = 0, n_bad = 0;
  int t, retries, wd;
  bit failed;
  always #5 clk = ~clk;
  bsg_link_bringup_sequencer #(.phase_cycles_p(P), .num_links_p(N), .max_retries_p(MR), .timeout_cycles_p(TO)) dut
    (.clk_i(clk), .reset_i(reset_i), .restart_i(restart_i), .link_error_i(link_error_i), .link_up_i(link_up_i),
     .link_reset_o(link_reset_o), .chip_reset_o(chip_reset_o), .link_enable_o(link_enable_o),
     .node_en_o(node_en_o), .done_o(done_o), .fail_o(fail_o), .retry_count_o(retry_count_o));
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    t = 0;
    retries = 0;
    wd = 0;
    failed = 0;
  endtask
  task automatic model_step(input logic r, input logic [N-1:0] err, input logic [N-1:0] up);
    bit done_pre, wd_ev, ev;
    done_pre = !failed && t >= DONE_T;
    wd_ev = 0;
`ifdef BSG_LINK_BRINGUP_TIMEOUT_EN
    if (done_pre && !(&up)) begin
      wd++;
      wd_ev = wd >= TO;
    end else wd = 0;
`else
    wd = (up == '1) ? 0 : wd;
`endif
    ev = !failed && (r || (done_pre && |err) || wd_ev);
    if (ev) begin
      wd = 0;
      if (retries == MR) failed = 1;
      else begin
        retries++;
        t = 0;
      end
    end else if (!failed && t < DONE_T) t++;
  endtask
  task automatic check_outputs(input string ph);
    logic [N-1:0] ne;
    for (int i = 0; i < N; i++) ne[i] = !failed && t >= (5 + i) * P;
    check_eq({ph, ".link_reset"}, 32'(link_reset_o), 32'(!failed && t >= P && t < 2 * P));
    check_eq({ph, ".chip_reset"}, 32'(chip_reset_o), 32'(failed || t < 4 * P));
    check_eq({ph, ".link_enable"}, 32'(link_enable_o), (!failed && t >= 3 * P) ? 32'((1 << N) - 1) : 32'd0);
    check_eq({ph, ".node_en"}, 32'(node_en_o), 32'(ne));
    check_eq({ph, ".done"}, 32'(done_o), 32'(!failed && t >= DONE_T));
    check_eq({ph, ".fail"}, 32'(fail_o), 32'(failed));
    check_eq({ph, ".retry_count"}, 32'(retry_count_o), 32'(retries));
  endtask
  task automatic cycle(input string ph, input logic r, input logic [N-1:0] err, input logic [N-1:0] up);
    restart_i = r;
    link_error_i = err;
    link_up_i = up;
    @(posedge clk);
    model_step(r, err, up);
    #1 check_outputs(ph);
    @(negedge clk);
  endtask
  initial begin
    logic [N-1:0] up_v, err_v;
    reset_i = 1'b1;
    restart_i = 1'b0;
    link_error_i = '0;
    link_up_i = '1;
    model_reset();
    #12 check_outputs("reset");
    @(negedge clk) reset_i = 1'b0;
    for (int c = 0; c < 14; c++) cycle("nominal", 1'b0, '0, '1);
    cycle("restart_len", 1'b1, '0, '1);
    for (int c = 0; c < 30; c++) cycle("replay", 1'b0, '0, '1);
    for (int k = 0; k < 5; k++) begin
      cycle("both_in_done", 1'b1, 2'b10, '1);
      for (int c = 0; c < DONE_T + 2; c++) cycle("err_replay", 1'b0, '0, '1);
    end
    for (int c = 0; c < 3; c++) cycle("fail_hold", 1'b1, 2'b11, '1);
    reset_i = 1'b1;
    #1 model_reset();
    check_outputs("fail_reset");
    #1 reset_i = 1'b0;
    for (int c = 0; c < 21; c++) cycle("to_node", 1'b0, '0, '1);
    reset_i = 1'b1;
    #1 model_reset();
    check_outputs("async_node");
    #1 reset_i = 1'b0;
    up_v = '1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(199) == 0) begin
        reset_i = 1'b1;
        #1 model_reset();
        check_outputs("async_rand");
        #1 reset_i = 1'b0;
      end
      if (c % 16 == 0) up_v = ($urandom_range(2) == 0) ? N'($urandom) : '1;
      err_v = ($urandom_range(19) == 0) ? N'($urandom) : '0;
      cycle("random", $urandom_range(49) == 0, err_v, up_v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bsg_link_bringup_sequencer.md
Name: bsg_link_bringup_sequencer

Overview:
- Parametrised power-on and retrain sequencer for DDR-link/tunnel/router/node stacks in the loopback ASIC and gateway tops.
- Walks the fixed bring-up order: link reset pulse, then link enable, then chip reset release, then per-link node enable. Each phase lasts a programmable number of cycles.
- Adds what the hand-coded sequence lacks:
  - a configurable link count with staggered node enables;
  - automatic restart on link error or on request;
  - a saturating retry budget that ends in a terminal FAIL state.

Parameters:
- phase_cycles_p, 5000: cycles spent in each timed phase; must be >= 1.
- num_links_p, 2: number of links/nodes; each gets its own link_enable_o and node_en_o bit.
- max_retries_p, 3: restart events tolerated before FAIL; must be >= 0.
- timeout_cycles_p, 65536: link-up watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- restart_i  in  1  synchronous restart request pulse, from software or chipscope.
- link_error_i  in  num_links_p  per-link error flags; sampled only in S_DONE.
- link_up_i  in  num_links_p  per-link "traffic alive" flags; ignored unless the optional feature is compiled in.
- link_reset_o  out  1  DDR link reset (reset_i of bsg_link_ddr).
- chip_reset_o  out  1  reset for channel tunnel, routers and adapters.
- link_enable_o  out  num_links_p  link_enable_i per link.
- node_en_o  out  num_links_p  adapter en_i per link.
- done_o  out  1  sequence complete.
- fail_o  out  1  retry budget exhausted.
- retry_count_o  out  $clog2(max_retries_p+1)  restart events counted so far (saturating).

Behaviour:
- All outputs are registered.
- Reset values, while reset_i is high: link_reset_o=0, chip_reset_o=1, link_enable_o=0, node_en_o=0, done_o=0, fail_o=0, retry_count_o=0, state=S_PRE, phase count=0, link index=0.
- Phase timer: the count runs 0 to phase_cycles_p-1. The transition and its output change happen on the edge where count==phase_cycles_p-1, and the count then returns to 0. Each timed phase therefore lasts exactly phase_cycles_p cycles.
- States and the output change made on exit:
  - S_PRE to S_LRST: link_reset_o goes 1.
  - S_LRST to S_POST: link_reset_o goes 0.
  - S_POST to S_LEN: link_enable_o goes all-ones.
  - S_LEN to S_NODE: chip_reset_o goes 0.
- S_NODE: at each phase expiry, set node_en_o[link index] and increment the link index. When the last link is enabled, go to S_DONE and set done_o=1. This is num_links_p phases in total.
- S_DONE: holds all outputs.
- Restart events:
  - Sources: restart_i in any state except S_FAIL, or any link_error_i bit while in S_DONE.
  - Simultaneous sources on one edge count as one event.
  - If retry_count_o < max_retries_p: increment it and, on the same edge, return all outputs except retry_count_o to their reset values, with state=S_PRE and the timer cleared. The full sequence then replays.
  - If retry_count_o == max_retries_p: go to S_FAIL.
- S_FAIL: fail_o=1, chip_reset_o=1, link_reset_o=0, link_enable_o=0, node_en_o=0, done_o=0. Only reset_i exits S_FAIL; restart_i is ignored.
- An asynchronous reset in any state, including mid-phase, forces the reset values immediately and clears retry_count_o.
- A restart event takes priority over a phase expiry on the same edge.

Optional Feature:
- Macro: BSG_LINK_BRINGUP_TIMEOUT_EN.
- When defined: a watchdog counter starts on entry to S_DONE. If any link_up_i bit has been 0 for timeout_cycles_p consecutive cycles, that is a restart event with the same retry rules. The watchdog clears once all link_up_i bits are 1 and whenever the state leaves S_DONE.
- When not defined: link_up_i is unused, no watchdog logic is synthesised, and S_DONE exits only on restart_i or link_error_i.

Decomposition:
- Shared package bsg_link_bringup_pkg holds:
  - the state enum typedef (S_PRE, S_LRST, S_POST, S_LEN, S_NODE, S_DONE, S_FAIL);
  - a function giving the timer width, $clog2(phase_cycles_p).
- One sub-module, bsg_bringup_phase_timer: a clear-able up-counter with an expire pulse, parametrised by cycle count. The same timer is reused for the watchdog.

Test Plan:
- Nominal sequence; phase_cycles_p=4, num_links_p=2; release reset_i at edge 0 -> link_reset_o=1 after edge 4 and 0 after edge 8; link_enable_o=2'b11 after edge 12; chip_reset_o=0 after edge 16; node_en_o=2'b01 after edge 20; node_en_o=2'b11 and done_o=1 after edge 24.
- restart_i pulse at edge 14 (in S_LEN) -> after edge 14 all outputs are at reset values and retry_count_o=1; link_reset_o rises again after edge 18.
- link_error_i=2'b10 in S_DONE, with max_retries_p=3 -> three errors each give a replay and retry_count_o=1,2,3; the fourth error gives fail_o=1 and chip_reset_o=1, and a later restart_i has no effect.
- restart_i and link_error_i asserted together in S_DONE -> retry_count_o increments by exactly 1.
- Assert reset_i asynchronously between edges in S_NODE -> outputs go to reset values before the next edge and retry_count_o=0.
- With BSG_LINK_BRINGUP_TIMEOUT_EN and timeout_cycles_p=8; link_up_i=2'b01 held in S_DONE -> restart event 8 cycles after S_DONE entry. With link_up_i=2'b11 -> no restart after 100 cycles.
